// File: rtl/icache_pkg.sv
// Shared types, field widths and address field helpers for the way0 instruction cache.
package icache_pkg;

  localparam int IC_INDEX_WIDTH     = 6;
  localparam int IC_WORDS_PER_LINE  = 4;
  localparam int IC_OFFSET_WIDTH    = 2;
  // Byte address bit where the line index starts (word offset + byte offset).
  localparam int IC_LINE_LSB        = IC_OFFSET_WIDTH + 2;
  localparam int IC_TAG_WIDTH       = 32 - IC_INDEX_WIDTH - IC_LINE_LSB;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_REFILL = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic logic [IC_OFFSET_WIDTH-1:0] addr_offset(input logic [31:0] a);
    return a[3:2];
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] a, input int iw);
    return (a >> IC_LINE_LSB) & ((32'd1 << iw) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int iw);
    return a >> (IC_LINE_LSB + iw);
  endfunction

endpackage

// File: rtl/icache_array_way0.sv
// Tag and data storage for the way0 instruction cache: combinational read by index,
// synchronous word and tag writes. Storage is intentionally not reset.
module icache_array_way0
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH    = IC_INDEX_WIDTH,
  parameter int WORDS_PER_LINE = IC_WORDS_PER_LINE,
  parameter int TAG_WIDTH      = 32 - INDEX_WIDTH - IC_LINE_LSB
) (
  input  logic                       clk,
  input  logic [INDEX_WIDTH-1:0]     rd_idx,
  input  logic [IC_OFFSET_WIDTH-1:0] rd_off,
  output logic [TAG_WIDTH-1:0]       rd_tag,
  output logic [31:0]                rd_word,
  input  logic                       word_we,
  input  logic [INDEX_WIDTH-1:0]     wr_idx,
  input  logic [IC_OFFSET_WIDTH-1:0] wr_off,
  input  logic [31:0]                wr_word,
  input  logic                       tag_we,
  input  logic [TAG_WIDTH-1:0]       wr_tag
);

  localparam int NUM_LINES = 1 << INDEX_WIDTH;

  logic [TAG_WIDTH-1:0] tag_mem  [NUM_LINES];
  logic [31:0]          data_mem [NUM_LINES*WORDS_PER_LINE];

  assign rd_tag  = tag_mem[rd_idx];
  assign rd_word = data_mem[{rd_idx, rd_off}];

  always_ff @(posedge clk) begin
    if (word_we) data_mem[{wr_idx, wr_off}] <= wr_word;
    if (tag_we)  tag_mem[wr_idx] <= wr_tag;
  end

endmodule

// File: rtl/icache_way0.sv
// Direct-mapped read-only instruction cache for the way0 fetch unit.
// Optional hit/miss counters are enabled by defining ICACHE_STAT_EN.
//
// state  | meaning
// IDLE   | apply pending/new fence, else accept a fetch request
// LOOKUP | compare tag; hit answers, miss starts a line refill
// REFILL | fetch 4 words from memory in order, install line
// DONE   | return the critical word unless the request was aborted
module icache_way0
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH    = IC_INDEX_WIDTH,
  parameter int WORDS_PER_LINE = IC_WORDS_PER_LINE,
  parameter int TAG_WIDTH      = 32 - INDEX_WIDTH - 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        request_i,
  input  logic [31:0] instAddr_i,
  input  logic        abort_i,
  input  logic        fenceI_i,
  output logic        dataOk_o,
  output logic [31:0] inst_o,
  output logic        memReq_o,
  output logic [31:0] memAddr_o,
  input  logic        memDataOk_i,
  input  logic [31:0] memData_i
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0] hitCnt_o,
  output logic [31:0] missCnt_o
`endif
);

  localparam int NUM_LINES = 1 << INDEX_WIDTH;

  state_t                     state;
  logic [31:0]                req_addr;
  logic [IC_OFFSET_WIDTH-1:0] cnt;
  logic [NUM_LINES-1:0]       valid;
  logic                       fence_pend;
  logic                       aborted;
  logic [31:0]                crit_word;

  logic [INDEX_WIDTH-1:0]     req_idx;
  logic [TAG_WIDTH-1:0]       req_tag;
  logic [IC_OFFSET_WIDTH-1:0] req_off;
  logic [TAG_WIDTH-1:0]       arr_tag;
  logic [31:0]                arr_word;
  logic                       hit;
  logic                       fill_we;
  logic                       fill_last;

  assign req_idx   = INDEX_WIDTH'(addr_index(req_addr, INDEX_WIDTH));
  assign req_tag   = TAG_WIDTH'(addr_tag(req_addr, INDEX_WIDTH));
  assign req_off   = addr_offset(req_addr);
  assign hit       = valid[req_idx] && (arr_tag == req_tag);
  assign fill_we   = (state == ST_REFILL) && memDataOk_i;
  assign fill_last = fill_we && (cnt == 2'd3);

  icache_array_way0 #(
    .INDEX_WIDTH   (INDEX_WIDTH),
    .WORDS_PER_LINE(WORDS_PER_LINE),
    .TAG_WIDTH     (TAG_WIDTH)
  ) u_array (
    .clk    (clk),
    .rd_idx (req_idx),
    .rd_off (req_off),
    .rd_tag (arr_tag),
    .rd_word(arr_word),
    .word_we(fill_we),
    .wr_idx (req_idx),
    .wr_off (cnt),
    .wr_word(memData_i),
    .tag_we (fill_last),
    .wr_tag (req_tag)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      req_addr   <= '0;
      cnt        <= '0;
      valid      <= '0;
      fence_pend <= 1'b0;
      aborted    <= 1'b0;
      crit_word  <= '0;
      dataOk_o   <= 1'b0;
      inst_o     <= '0;
      memReq_o   <= 1'b0;
      memAddr_o  <= '0;
    end else begin
      dataOk_o <= 1'b0;
      if (state != ST_IDLE && fenceI_i) fence_pend <= 1'b1;
      case (state)
        ST_IDLE: begin
          // A fence wins over a new request, which is then taken a cycle later.
          if (fenceI_i || fence_pend) begin
            valid      <= '0;
            fence_pend <= 1'b0;
          end else if (request_i) begin
            req_addr <= instAddr_i;
            aborted  <= 1'b0;
            state    <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (abort_i) begin
            state <= ST_IDLE;
          end else if (hit) begin
            dataOk_o <= 1'b1;
            inst_o   <= arr_word;
            state    <= ST_IDLE;
          end else begin
            cnt       <= '0;
            memReq_o  <= 1'b1;
            memAddr_o <= {req_tag, req_idx, 2'b00, 2'b00};
            state     <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (abort_i) aborted <= 1'b1;
          if (memDataOk_i) begin
            if (cnt == req_off) crit_word <= memData_i;
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              valid[req_idx] <= 1'b1;
              memReq_o       <= 1'b0;
              state          <= ST_DONE;
            end else begin
              memAddr_o <= {req_tag, req_idx, cnt + 2'd1, 2'b00};
            end
          end
        end
        ST_DONE: begin
          if (!aborted && !abort_i) begin
            dataOk_o <= 1'b1;
            inst_o   <= crit_word;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ICACHE_STAT_EN
  // Every lookup is counted, including ones whose response is later suppressed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hitCnt_o  <= '0;
      missCnt_o <= '0;
    end else if (state == ST_LOOKUP) begin
      if (hit) hitCnt_o  <= hitCnt_o + 32'd1;
      else     missCnt_o <= missCnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_way0.sv
// Directed self-checking bench for icache_way0 (default build, stats disabled).
module tb_icache_way0;

  logic        clk;
  logic        reset;
  logic        request_i;
  logic [31:0] instAddr_i;
  logic        abort_i;
  logic        fenceI_i;
  logic        dataOk_o;
  logic [31:0] inst_o;
  logic        memReq_o;
  logic [31:0] memAddr_o;
  logic        memDataOk_i;
  logic [31:0] memData_i;

  int n_pass  = 0;
  int n_total = 0;

  icache_way0 dut (
    .clk        (clk),
    .reset      (reset),
    .request_i  (request_i),
    .instAddr_i (instAddr_i),
    .abort_i    (abort_i),
    .fenceI_i   (fenceI_i),
    .dataOk_o   (dataOk_o),
    .inst_o     (inst_o),
    .memReq_o   (memReq_o),
    .memAddr_o  (memAddr_o),
    .memDataOk_i(memDataOk_i),
    .memData_i  (memData_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One fetch: request, then either a hit two cycles later or a serviced 4-word refill.
  // abort_k/fence_k select the refill word during which abort_i/fenceI_i pulse (-1: never).
  task automatic fetch(input string nm, input logic [31:0] a, input logic exp_miss,
                       input logic [31:0] d0, input int abort_k, input int fence_k,
                       input logic [31:0] exp_inst);
    logic exp_ok;
    exp_ok     = (abort_k < 0);
    request_i  = 1'b1;
    instAddr_i = a;
    tick();
    tick();
    chk({nm, "_hit_ok"}, {31'd0, dataOk_o}, {31'd0, !exp_miss});
    chk({nm, "_memreq"}, {31'd0, memReq_o}, {31'd0, exp_miss});
    if (!exp_miss) begin
      chk({nm, "_hit_inst"}, inst_o, exp_inst);
    end else begin
      for (int k = 0; k < 4; k++) begin
        chk({nm, "_fill_req"}, {31'd0, memReq_o}, 32'd1);
        chk({nm, "_fill_addr"}, memAddr_o, {a[31:4], 4'h0} + 32'(4 * k));
        memDataOk_i = 1'b1;
        memData_i   = d0 + 32'(k);
        if (k == abort_k) begin
          abort_i   = 1'b1;
          request_i = 1'b0;
        end
        if (k == fence_k) fenceI_i = 1'b1;
        tick();
        abort_i  = 1'b0;
        fenceI_i = 1'b0;
      end
      memDataOk_i = 1'b0;
      chk({nm, "_req_drop"}, {31'd0, memReq_o}, 32'd0);
      chk({nm, "_early_ok"}, {31'd0, dataOk_o}, 32'd0);
      tick();
      chk({nm, "_done_ok"}, {31'd0, dataOk_o}, {31'd0, exp_ok});
      if (exp_ok) chk({nm, "_done_inst"}, inst_o, exp_inst);
    end
    request_i = 1'b0;
    tick();
    chk({nm, "_pulse"}, {31'd0, dataOk_o}, 32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    request_i   = 1'b0;
    instAddr_i  = '0;
    abort_i     = 1'b0;
    fenceI_i    = 1'b0;
    memDataOk_i = 1'b0;
    memData_i   = '0;
    tick();
    chk("rst_dataok", {31'd0, dataOk_o}, 32'd0);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_memreq", {31'd0, memReq_o}, 32'd0);
    chk("rst_memaddr", memAddr_o, 32'd0);
    reset = 1'b0;
    tick();

    fetch("cold", 32'h0000_1004, 1'b1, 32'hA0, -1, -1, 32'hA1);
    fetch("hit", 32'h0000_100C, 1'b0, 32'h0, -1, -1, 32'hA3);
    fetch("conflict", 32'h0000_1404, 1'b1, 32'hB0, -1, -1, 32'hB1);
    fetch("rehit_old", 32'h0000_1004, 1'b1, 32'hA0, -1, -1, 32'hA1);

    fetch("abort", 32'h0000_2048, 1'b1, 32'hC0, 1, -1, 32'h0);
    fetch("abort_hit", 32'h0000_2048, 1'b0, 32'h0, -1, -1, 32'hC2);
    chk("inst_hold", inst_o, 32'hC2);

    fetch("fence", 32'h0000_3000, 1'b1, 32'hD0, -1, 1, 32'hD0);
    fetch("post_fence", 32'h0000_3000, 1'b1, 32'hE0, -1, -1, 32'hE0);
    fetch("post_fence_hit", 32'h0000_3000, 1'b0, 32'h0, -1, -1, 32'hE0);

    // Line 0x2040 was wiped by the fence, so this request enters REFILL.
    request_i  = 1'b1;
    instAddr_i = 32'h0000_2048;
    tick();
    tick();
    chk("rst_pre_memreq", {31'd0, memReq_o}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_memreq", {31'd0, memReq_o}, 32'd0);
    chk("rst_async_memaddr", memAddr_o, 32'd0);
    request_i = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    fetch("rst_after", 32'h0000_3000, 1'b1, 32'hF0, -1, -1, 32'hF0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
